fetch_sequencer: RTL and testbench

//  Owns PC_FETCH for the 2-stage (FETCH -> EX/WB) RV32I core. Selects the next PC (sequential/branch/jal/jalr),

---
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the control unit / instruction memory side and the fetch sequencer.
// master: the environment driving EX-stage resolution and debug requests; slave: the sequencer.
interface fetch_sequencer_if #(
  parameter int IMEM_AW = 12
);
  logic [1:0]         pcsrc_EX;
  logic [31:0]        branch_addr;
  logic [31:0]        jal_addr;
  logic [31:0]        jalr_addr;
  logic               stall_EX;
  logic               halt_req;
  logic               step_req;
  logic [31:0]        pc_F;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc_EX;
  logic               valid_EX;
  logic               flush_F;
  logic               stall_FETCH;
  logic               halted;
  logic               trap;
  logic [31:0]        trap_addr;
  logic [31:0]        instret;

  modport master (
    output pcsrc_EX, branch_addr, jal_addr, jalr_addr, stall_EX, halt_req, step_req,
    input  pc_F, imem_addr, pc_EX, valid_EX, flush_F, stall_FETCH, halted, trap,
           trap_addr, instret
  );

  modport slave (
    input  pcsrc_EX, branch_addr, jal_addr, jalr_addr, stall_EX, halt_req, step_req,
    output pc_F, imem_addr, pc_EX, valid_EX, flush_F, stall_FETCH, halted, trap,
           trap_addr, instret
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC_FETCH owner for the 2-stage RV32I core: next-PC select, wrong-path squash, EX stall,
// debug halt/single-step, misaligned-target trap and retired-instruction counter.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic            clk,
  input  logic            res,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    RUN,
    HALT,
    STEP_F,
    STEP_X,
    TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_F_q, pc_F_d;
  logic [31:0] pc_EX_q, pc_EX_d;
  logic        valid_EX_q, valid_EX_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] instret_q, instret_d;

  logic [31:0] target;
  logic        redirect;
  logic        misalign;
  logic        flush;
  logic        stall_fetch;

  always_comb begin
    target = '0;
    unique case (bus.pcsrc_EX)
      2'b01:   target = bus.branch_addr;
      2'b10:   target = bus.jal_addr;
      2'b11:   target = bus.jalr_addr & ~32'd1;
      default: target = '0;
    endcase
  end

  assign redirect = valid_EX_q & ~bus.stall_EX & (bus.pcsrc_EX != 2'b00);
  assign misalign = redirect & target[1];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (!bus.stall_EX) begin
          if (misalign)          state_d = TRAP;
          else if (redirect)     state_d = bus.halt_req ? HALT : RUN;
          else if (bus.halt_req) state_d = HALT;
        end
      end
      HALT: begin
        if (bus.step_req)       state_d = STEP_F;
        else if (!bus.halt_req) state_d = RUN;
      end
      STEP_F: state_d = STEP_X;
      STEP_X: begin
        if (!bus.stall_EX) state_d = misalign ? TRAP : HALT;
      end
      TRAP:    state_d = TRAP;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flush       = 1'b0;
    stall_fetch = 1'b0;
    pc_F_d      = pc_F_q;
    pc_EX_d     = pc_EX_q;
    valid_EX_d  = valid_EX_q;
    trap_addr_d = trap_addr_q;
    unique case (state_q)
      RUN: begin
        if (bus.stall_EX) begin
          stall_fetch = 1'b1;
        end else if (misalign) begin
          flush       = 1'b1;
          trap_addr_d = target;
          valid_EX_d  = 1'b0;
        end else if (redirect) begin
          flush      = 1'b1;
          pc_F_d     = target;
          valid_EX_d = 1'b0;
        end else if (bus.halt_req) begin
          // pc_F is left on the next unexecuted instruction so resume restarts there
          flush      = 1'b1;
          valid_EX_d = 1'b0;
        end else begin
          pc_EX_d    = pc_F_q;
          valid_EX_d = 1'b1;
          pc_F_d     = pc_F_q + 32'd4;
        end
      end
      HALT: begin
        flush      = 1'b1;
        valid_EX_d = 1'b0;
      end
      STEP_F: begin
        pc_EX_d    = pc_F_q;
        valid_EX_d = 1'b1;
        pc_F_d     = pc_F_q + 32'd4;
      end
      STEP_X: begin
        flush = 1'b1;
        if (bus.stall_EX) begin
          stall_fetch = 1'b1;
        end else begin
          valid_EX_d = 1'b0;
          if (misalign)      trap_addr_d = target;
          else if (redirect) pc_F_d = target;
        end
      end
      TRAP: begin
        flush      = 1'b1;
        valid_EX_d = 1'b0;
      end
      default: begin
        flush      = 1'b1;
        valid_EX_d = 1'b0;
      end
    endcase
  end

  assign instret_d = instret_q + {31'd0, valid_EX_q & ~bus.stall_EX};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pc_F_q      <= RESET_PC;
      pc_EX_q     <= '0;
      valid_EX_q  <= 1'b0;
      trap_addr_q <= '0;
      instret_q   <= '0;
    end else begin
      pc_F_q      <= pc_F_d;
      pc_EX_q     <= pc_EX_d;
      valid_EX_q  <= valid_EX_d;
      trap_addr_q <= trap_addr_d;
      instret_q   <= instret_d;
    end
  end

  assign bus.pc_F        = pc_F_q;
  assign bus.imem_addr   = pc_F_q[IMEM_AW+1:2];
  assign bus.pc_EX       = pc_EX_q;
  assign bus.valid_EX    = valid_EX_q;
  assign bus.flush_F     = flush;
  assign bus.stall_FETCH = stall_fetch;
  assign bus.halted      = (state_q == HALT);
  assign bus.trap        = (state_q == TRAP);
  assign bus.trap_addr   = trap_addr_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, branch/jal/jalr redirect, stall,
// debug halt/step, misaligned trap, address wrap and asynchronous reset.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic res = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.IMEM_AW(12)) bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_AW(12)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  // {pc_F, pc_EX, valid_EX, instret}
  function automatic logic [96:0] snap();
    return {bus.pc_F, bus.pc_EX, bus.valid_EX, bus.instret};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pcsrc_EX = 2'b00; bus.branch_addr = '0; bus.jal_addr = '0; bus.jalr_addr = '0;
    bus.stall_EX = 1'b0;  bus.halt_req = 1'b0;  bus.step_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [102:0] got;
    clear_inputs();
    res = 1'b0;
    #12;
    got = {bus.pc_F, bus.pc_EX, bus.valid_EX, bus.trap_addr, bus.instret,
           bus.flush_F, bus.stall_FETCH, bus.halted, bus.trap, bus.imem_addr[1:0]};
    total++;
    if (got !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", got); end
    tick();
    res = 1'b1;
    #1;
    total++;
    if (snap() !== {32'h0, 32'h0, 1'b0, 32'd0}) begin
      bad++; $display("FAIL reset_release got=%h", snap());
    end
  endtask

  task automatic test_sequential();
    logic [96:0] e;
    for (int unsigned i = 1; i <= 4; i++) begin
      tick();
      e = {32'(4 * i), 32'(4 * (i - 1)), 1'b1, 32'(i - 1)};
      total++;
      if (snap() !== e) begin bad++; $display("FAIL seq_c%0d got=%h exp=%h", i, snap(), e); end
      total++;
      if (bus.imem_addr !== 12'(i)) begin
        bad++; $display("FAIL seq_imem_c%0d got=%h exp=%h", i, bus.imem_addr, 12'(i));
      end
    end
  endtask

  task automatic test_branch();
    logic [96:0] e;
    bus.pcsrc_EX = 2'b01; bus.branch_addr = 32'h40;
    #1;
    total++;
    if (bus.flush_F !== 1'b1) begin bad++; $display("FAIL br_flush got=%b exp=1", bus.flush_F); end
    tick();
    bus.branch_addr = 32'h99;  // bubble slot: must be ignored
    #1;
    e = {32'h40, 32'hC, 1'b0, 32'd4};
    total++;
    if (snap() !== e) begin bad++; $display("FAIL br_target got=%h exp=%h", snap(), e); end
    total++;
    if (bus.flush_F !== 1'b0) begin bad++; $display("FAIL br_bubble_flush got=%b exp=0", bus.flush_F); end
    tick();
    bus.pcsrc_EX = 2'b00;
    e = {32'h44, 32'h40, 1'b1, 32'd4};
    total++;
    if (snap() !== e) begin bad++; $display("FAIL br_after got=%h exp=%h", snap(), e); end
  endtask

  task automatic test_stall();
    logic [96:0] e;
    bus.stall_EX = 1'b1; bus.pcsrc_EX = 2'b10; bus.jal_addr = 32'h200;
    #1;
    total++;
    if ({bus.stall_FETCH, bus.flush_F} !== 2'b10) begin
      bad++; $display("FAIL st_ctrl got=%b exp=10", {bus.stall_FETCH, bus.flush_F});
    end
    e = {32'h44, 32'h40, 1'b1, 32'd4};
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      total++;
      if (snap() !== e) begin bad++; $display("FAIL st_hold%0d got=%h exp=%h", i, snap(), e); end
    end
    bus.stall_EX = 1'b0;
    #1;
    total++;
    if (bus.flush_F !== 1'b1) begin bad++; $display("FAIL st_release_flush got=%b exp=1", bus.flush_F); end
    tick();
    bus.pcsrc_EX = 2'b00;
    e = {32'h200, 32'h40, 1'b0, 32'd5};
    total++;
    if (snap() !== e) begin bad++; $display("FAIL st_jal got=%h exp=%h", snap(), e); end
    tick();
    tick();
    e = {32'h208, 32'h204, 1'b1, 32'd6};
    total++;
    if (snap() !== e) begin bad++; $display("FAIL st_after got=%h exp=%h", snap(), e); end
  endtask

  task automatic test_halt_step();
    logic [96:0] e;
    bus.pcsrc_EX = 2'b10; bus.jal_addr = 32'h20;
    tick();
    bus.pcsrc_EX = 2'b00; bus.halt_req = 1'b1;
    #1;
    total++;
    if (bus.flush_F !== 1'b1) begin bad++; $display("FAIL hs_flush got=%b exp=1", bus.flush_F); end
    e = {32'h20, 32'h204, 1'b0, 32'd7};
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({snap(), bus.halted} !== {e, 1'b1}) begin
        bad++; $display("FAIL hs_halted%0d got=%h/%b exp=%h/1", i, snap(), bus.halted, e);
      end
    end
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
    e = {32'h24, 32'h20, 1'b1, 32'd7};
    total++;
    if ({snap(), bus.halted, bus.flush_F} !== {e, 2'b01}) begin
      bad++; $display("FAIL hs_stepx got=%h/%b%b exp=%h/01", snap(), bus.halted, bus.flush_F, e);
    end
    tick();
    e = {32'h24, 32'h20, 1'b0, 32'd8};
    total++;
    if ({snap(), bus.halted} !== {e, 1'b1}) begin
      bad++; $display("FAIL hs_rehalt got=%h/%b exp=%h/1", snap(), bus.halted, e);
    end
    bus.halt_req = 1'b0;
    tick();
    tick();
    e = {32'h28, 32'h24, 1'b1, 32'd8};
    total++;
    if ({snap(), bus.halted} !== {e, 1'b0}) begin
      bad++; $display("FAIL hs_resume got=%h/%b exp=%h/0", snap(), bus.halted, e);
    end
  endtask

  task automatic test_trap();
    logic [96:0] e;
    bus.pcsrc_EX = 2'b11; bus.jalr_addr = 32'h103;
    #1;
    total++;
    if (bus.flush_F !== 1'b1) begin bad++; $display("FAIL tr_flush got=%b exp=1", bus.flush_F); end
    tick();
    bus.pcsrc_EX = 2'b00;
    e = {32'h28, 32'h24, 1'b0, 32'd9};
    total++;
    if ({snap(), bus.trap, bus.trap_addr} !== {e, 1'b1, 32'h102}) begin
      bad++; $display("FAIL tr_enter got=%h/%b/%h exp=%h/1/102", snap(), bus.trap, bus.trap_addr, e);
    end
    bus.halt_req = 1'b1;
    tick();
    tick();
    total++;
    if ({snap(), bus.trap, bus.halted, bus.trap_addr} !== {e, 2'b10, 32'h102}) begin
      bad++; $display("FAIL tr_stuck got=%h/%b%b/%h exp=%h/10/102",
                      snap(), bus.trap, bus.halted, bus.trap_addr, e);
    end
    clear_inputs();
    res = 1'b0;
    #1;
    total++;
    if ({bus.trap, bus.trap_addr, bus.pc_F} !== {1'b0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL tr_reset got=%b/%h/%h exp=0/0/0", bus.trap, bus.trap_addr, bus.pc_F);
    end
    tick();
    res = 1'b1;
  endtask

  task automatic test_jalr_wrap();
    logic [96:0] e;
    tick();
    bus.pcsrc_EX = 2'b11; bus.jalr_addr = 32'h41;
    tick();
    bus.pcsrc_EX = 2'b00;
    e = {32'h40, 32'h0, 1'b0, 32'd1};
    total++;
    if ({snap(), bus.trap} !== {e, 1'b0}) begin
      bad++; $display("FAIL jw_jalr got=%h/%b exp=%h/0", snap(), bus.trap, e);
    end
    tick();
    bus.pcsrc_EX = 2'b10; bus.jal_addr = 32'hFFFF_FFFC;
    tick();
    bus.pcsrc_EX = 2'b00;
    total++;
    if ({bus.pc_F, bus.imem_addr, bus.instret} !== {32'hFFFF_FFFC, 12'hFFF, 32'd2}) begin
      bad++; $display("FAIL jw_top got=%h/%h/%0d exp=fffffffc/fff/2", bus.pc_F, bus.imem_addr, bus.instret);
    end
    tick();
    total++;
    if ({bus.pc_F, bus.imem_addr, bus.pc_EX, bus.valid_EX} !== {32'h0, 12'h0, 32'hFFFF_FFFC, 1'b1}) begin
      bad++; $display("FAIL jw_wrap got=%h/%h/%h/%b exp=0/0/fffffffc/1",
                      bus.pc_F, bus.imem_addr, bus.pc_EX, bus.valid_EX);
    end
    bus.pcsrc_EX = 2'b10; bus.jal_addr = 32'h4008;
    tick();
    bus.pcsrc_EX = 2'b00;
    total++;
    if ({bus.pc_F, bus.imem_addr, bus.instret} !== {32'h4008, 12'h2, 32'd3}) begin
      bad++; $display("FAIL jw_imem got=%h/%h/%0d exp=4008/002/3", bus.pc_F, bus.imem_addr, bus.instret);
    end
  endtask

  task automatic test_halt_redirect_reset();
    logic [96:0]  e;
    logic [102:0] got;
    tick();
    bus.pcsrc_EX = 2'b01; bus.branch_addr = 32'h80; bus.halt_req = 1'b1;
    tick();
    bus.pcsrc_EX = 2'b00;
    e = {32'h80, 32'h4008, 1'b0, 32'd4};
    total++;
    if ({snap(), bus.halted} !== {e, 1'b1}) begin
      bad++; $display("FAIL hr_halt got=%h/%b exp=%h/1", snap(), bus.halted, e);
    end
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0; bus.stall_EX = 1'b1;
    tick();
    tick();
    e = {32'h84, 32'h80, 1'b1, 32'd4};
    total++;
    if ({snap(), bus.stall_FETCH, bus.halted} !== {e, 2'b10}) begin
      bad++; $display("FAIL hr_stepx_stall got=%h/%b%b exp=%h/10", snap(), bus.stall_FETCH, bus.halted, e);
    end
    #2;
    clear_inputs();
    res = 1'b0;
    #1;
    got = {bus.pc_F, bus.pc_EX, bus.valid_EX, bus.trap_addr, bus.instret,
           bus.flush_F, bus.stall_FETCH, bus.halted, bus.trap, bus.imem_addr[1:0]};
    total++;
    if (got !== '0) begin bad++; $display("FAIL hr_async_reset got=%h exp=0", got); end
    tick();
    res = 1'b1;
    tick();
    e = {32'h4, 32'h0, 1'b1, 32'd0};
    total++;
    if ({snap(), bus.halted} !== {e, 1'b0}) begin
      bad++; $display("FAIL hr_no_pending got=%h/%b exp=%h/0", snap(), bus.halted, e);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt_step();
    test_trap();
    test_jalr_wrap();
    test_halt_redirect_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
